// File: rtl/mem_responder.sv
// Fixed-latency word memory responder for the cache-side memory interface.
// Define MEM_RESP_STALL_EN to add 0..3 LFSR-driven extra wait cycles per request.
module mem_responder #(
  parameter int         AW        = 10,
  parameter int         LATENCY   = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_ready,
  input  logic [31:0] i_mem_addr,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_valid,
  output logic        o_mem_wdone
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

`ifdef MEM_RESP_STALL_EN
  localparam int CW = 5;  // LATENCY-1 plus up to 3 stall cycles can exceed 15
`else
  localparam int CW = 4;
`endif

  logic [31:0]   mem_q [2**AW];
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [31:0]   pend_q, last_q;
  logic [CW-1:0] lat_m1;
  logic [AW-1:0] idx;
  logic          accept;
  logic          unused_ok;

  assign idx       = i_mem_addr[AW+1:2];
  assign unused_ok = ^{i_mem_addr[31:AW+2], i_mem_addr[1:0], LFSR_SEED};

  assign o_mem_ready = (state_q != S_WAIT);
  assign o_mem_valid = (state_q == S_RESP) && !wr_q;
  assign o_mem_wdone = (state_q == S_RESP) && wr_q;
  // Read data is presented only with valid; otherwise the last response is held.
  assign o_mem_rdata = o_mem_valid ? pend_q : last_q;
  assign accept      = o_mem_ready && (i_mem_ren || i_mem_wen);

`ifdef MEM_RESP_STALL_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lat_m1  = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst)       lfsr_q <= LFSR_SEED;
    else if (accept) lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end
`else
  assign lat_m1 = CW'(LATENCY - 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      wr_d    = i_mem_wen;  // write wins when both strobes are set
      cnt_d   = lat_m1;
      state_d = (lat_m1 == '0) ? S_RESP : S_WAIT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      pend_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      if (accept && i_mem_ren && !i_mem_wen) pend_q <= mem_q[idx];
      if (o_mem_valid) last_q <= pend_q;
    end
  end

  // Array survives reset; a write accepted before reset stays committed.
  always_ff @(posedge i_clk) begin
    if (accept && i_mem_wen) mem_q[idx] <= i_mem_wdata;
  end

endmodule
